alu_32bit: RTL and testbench

- Registered combinational ALU with a 4-bit function select. It computes one of nine arithmetic/logic/shift operations on two WIDTH-bit operands.
- The result and flags are captured into output registers on each rising clock edge.
- It is used as the datapath execution unit. The default build is 8 bits wide; the same RTL also serves the 32-bit datapath by setting WIDTH=32.

---
 rtl/alu_32bit.sv | 91 +++++++++
 tb/tb_alu_32bit.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_32bit.sv
// alu_32bit: registered ALU with a 4-bit function select.
// Computes one of nine arithmetic/logic/shift operations on two WIDTH-bit
// operands. Result, carry and zero are captured together on each rising
// edge, so there is exactly one cycle of latency and no input-to-output path.
module alu_32bit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       f,
    output logic [WIDTH-1:0] y,
    output logic             carry,
    output logic             zero
);

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_MUL = 4'd2,
        OP_AND = 4'd3,
        OP_OR  = 4'd4,
        OP_XOR = 4'd5,
        OP_NOT = 4'd6,
        OP_SHL = 4'd7,
        OP_SHR = 4'd8
    } op_e;

    // One extra bit on add/sub exposes carry-out and borrow directly.
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_diff;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_y;
    logic               w_carry;

    assign w_sum  = {1'b0, a} + {1'b0, b};
    assign w_diff = {1'b0, a} - {1'b0, b};
    // Operands widened first so the product keeps all 2*WIDTH bits.
    assign w_prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

    // Next-result and flag selection; reserved codes yield zero with no carry.
    always_comb begin
        w_y     = '0;
        w_carry = 1'b0;
        case (f)
            OP_ADD: begin
                w_y     = w_sum[WIDTH-1:0];
                w_carry = w_sum[WIDTH];
            end
            OP_SUB: begin
                w_y     = w_diff[WIDTH-1:0];
                w_carry = w_diff[WIDTH];
            end
            OP_MUL: begin
                w_y     = w_prod[WIDTH-1:0];
                w_carry = |w_prod[2*WIDTH-1:WIDTH];
            end
            OP_AND: w_y = a & b;
            OP_OR:  w_y = a | b;
            OP_XOR: w_y = a ^ b;
            OP_NOT: w_y = ~a;
            OP_SHL: begin
                w_y     = {a[WIDTH-2:0], 1'b0};
                w_carry = a[WIDTH-1];
            end
            OP_SHR: begin
                w_y     = {1'b0, a[WIDTH-1:1]};
                w_carry = a[0];
            end
            default: begin
                w_y     = '0;
                w_carry = 1'b0;
            end
        endcase
    end

    // Output registers; zero is derived from the same next value as y.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y     <= '0;
            carry <= 1'b0;
            zero  <= 1'b1;
        end else begin
            y     <= w_y;
            carry <= w_carry;
            zero  <= (w_y == '0);
        end
    end

endmodule

// File: tb/tb_alu_32bit.sv
// tb_alu_32bit: scoreboard bench for the registered ALU at WIDTH=8 and WIDTH=32.
module tb_alu_32bit;

    typedef struct {
        logic [63:0] y;
        logic        c;
        logic        z;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic [3:0]  f8 = '0, f32 = '0;
    logic [31:0] a32 = '0, b32 = '0;
    logic [7:0]  y8;
    logic [31:0] y32;
    logic        c8, z8, c32, z32;

    exp_t q8[$];
    exp_t q32[$];
    int   n_vec = 0;
    int   n_err = 0;

    alu_32bit #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .f(f8),
        .y(y8), .carry(c8), .zero(z8)
    );

    alu_32bit #(.WIDTH(32)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .a(a32), .b(b32), .f(f32),
        .y(y32), .carry(c32), .zero(z32)
    );

    always #5 clk = ~clk;

    // Drive one 8-bit operation and record what it must produce.
    task automatic push8(input logic [7:0] a, input logic [7:0] b, input logic [3:0] f,
                         input logic [7:0] ey, input logic ec, input logic ez);
        exp_t e;
        a8 = a; b8 = b; f8 = f;
        e.y = {56'h0, ey}; e.c = ec; e.z = ez;
        q8.push_back(e);
    endtask

    task automatic push32(input logic [31:0] a, input logic [31:0] b, input logic [3:0] f,
                          input logic [31:0] ey, input logic ec, input logic ez);
        exp_t e;
        a32 = a; b32 = b; f32 = f;
        e.y = {32'h0, ey}; e.c = ec; e.z = ez;
        q32.push_back(e);
    endtask

    // Independent reference for the 8-bit build, used by the random test.
    function automatic exp_t model8(input logic [7:0] a, input logic [7:0] b, input logic [3:0] f);
        exp_t e;
        int unsigned s;
        logic [7:0] r;
        logic c;
        r = 8'h00; c = 1'b0;
        case (f)
            4'd0: begin s = int'(a) + int'(b); r = s[7:0]; c = (s > 255); end
            4'd1: begin r = 8'(int'(a) - int'(b)); c = (a < b); end
            4'd2: begin s = int'(a) * int'(b); r = s[7:0]; c = (s > 255); end
            4'd3: r = a & b;
            4'd4: r = a | b;
            4'd5: r = a ^ b;
            4'd6: r = 8'(255 - int'(a));
            4'd7: begin s = int'(a) * 2; r = s[7:0]; c = (s > 255); end
            4'd8: begin r = 8'(int'(a) / 2); c = (a % 2 == 1); end
            default: begin r = 8'h00; c = 1'b0; end
        endcase
        e.y = {56'h0, r}; e.c = c; e.z = (r == 8'h00);
        return e;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        a8 = 8'h6B; b8 = 8'h4A; f8 = 4'd0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_vec++;
            if (y8 !== 8'h00 || c8 !== 1'b0 || z8 !== 1'b1) begin
                $display("FAIL reset_hold[%0d]: got y=%h c=%b z=%b, expected y=00 c=0 z=1", i, y8, c8, z8);
                n_err++;
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        push8(8'h6B, 8'h4A, 4'd0, 8'hB5, 1'b0, 1'b0);
        @(posedge clk); #1;
        begin
            exp_t e = q8.pop_front();
            n_vec++;
            if (y8 !== e.y[7:0] || c8 !== e.c || z8 !== e.z) begin
                $display("FAIL reset_release: got y=%h c=%b z=%b, expected y=%h c=%b z=%b",
                         y8, c8, z8, e.y[7:0], e.c, e.z);
                n_err++;
            end
        end
    endtask

    task automatic test_sweep();
        logic [7:0] ey [9];
        logic       ec [9];
        ey = '{8'hB5, 8'h21, 8'hEE, 8'h4A, 8'h6B, 8'h21, 8'h94, 8'hD6, 8'h35};
        ec = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 9; i++) begin
            exp_t e;
            push8(8'h6B, 8'h4A, 4'(i), ey[i], ec[i], 1'b0);
            @(posedge clk); #1;
            e = q8.pop_front();
            n_vec++;
            if (y8 !== e.y[7:0] || c8 !== e.c || z8 !== e.z) begin
                $display("FAIL sweep_f%0d: got y=%h c=%b z=%b, expected y=%h c=%b z=%b",
                         i, y8, c8, z8, e.y[7:0], e.c, e.z);
                n_err++;
            end
        end
    endtask

    task automatic test_reserved();
        for (int i = 9; i < 16; i++) begin
            exp_t e;
            push8(8'h6B, 8'h4A, 4'(i), 8'h00, 1'b0, 1'b1);
            @(posedge clk); #1;
            e = q8.pop_front();
            n_vec++;
            if (y8 !== e.y[7:0] || c8 !== e.c || z8 !== e.z) begin
                $display("FAIL reserved_f%0d: got y=%h c=%b z=%b, expected y=%h c=%b z=%b",
                         i, y8, c8, z8, e.y[7:0], e.c, e.z);
                n_err++;
            end
        end
    endtask

    task automatic test_wrap();
        logic [7:0] va [3], vb [3], vy [3];
        logic [3:0] vf [3];
        logic       vc [3], vz [3];
        va = '{8'hFF, 8'h00, 8'h4A};
        vb = '{8'h01, 8'h01, 8'h4A};
        vf = '{4'd0, 4'd1, 4'd1};
        vy = '{8'h00, 8'hFF, 8'h00};
        vc = '{1'b1, 1'b1, 1'b0};
        vz = '{1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            exp_t e;
            push8(va[i], vb[i], vf[i], vy[i], vc[i], vz[i]);
            @(posedge clk); #1;
            e = q8.pop_front();
            n_vec++;
            if (y8 !== e.y[7:0] || c8 !== e.c || z8 !== e.z) begin
                $display("FAIL wrap[%0d]: got y=%h c=%b z=%b, expected y=%h c=%b z=%b",
                         i, y8, c8, z8, e.y[7:0], e.c, e.z);
                n_err++;
            end
        end
    endtask

    // Back-to-back random operations, including reserved codes.
    task automatic test_back_to_back();
        for (int i = 0; i < 32; i++) begin
            exp_t e, m;
            logic [7:0] ra, rb;
            logic [3:0] rf;
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            rf = 4'($urandom_range(0, 15));
            m = model8(ra, rb, rf);
            push8(ra, rb, rf, m.y[7:0], m.c, m.z);
            @(posedge clk); #1;
            e = q8.pop_front();
            n_vec++;
            if (y8 !== e.y[7:0] || c8 !== e.c || z8 !== e.z) begin
                $display("FAIL b2b[%0d] a=%h b=%h f=%0d: got y=%h c=%b z=%b, expected y=%h c=%b z=%b",
                         i, ra, rb, rf, y8, c8, z8, e.y[7:0], e.c, e.z);
                n_err++;
            end
        end
    endtask

    task automatic test_latency();
        exp_t e;
        push8(8'h6B, 8'h4A, 4'd0, 8'hB5, 1'b0, 1'b0);
        @(posedge clk); #1;
        e = q8.pop_front();
        n_vec++;
        if (y8 !== e.y[7:0] || c8 !== e.c || z8 !== e.z) begin
            $display("FAIL lat_first: got y=%h c=%b z=%b, expected y=%h c=%b z=%b",
                     y8, c8, z8, e.y[7:0], e.c, e.z);
            n_err++;
        end
        // Mid-cycle function change must not reach y before the next edge.
        #2;
        push8(8'h6B, 8'h4A, 4'd5, 8'h21, 1'b0, 1'b0);
        #1;
        n_vec++;
        if (y8 !== 8'hB5) begin
            $display("FAIL lat_hold: got y=%h, expected y=b5 until next edge", y8);
            n_err++;
        end
        @(posedge clk); #1;
        e = q8.pop_front();
        n_vec++;
        if (y8 !== e.y[7:0] || c8 !== e.c || z8 !== e.z) begin
            $display("FAIL lat_next: got y=%h c=%b z=%b, expected y=%h c=%b z=%b",
                     y8, c8, z8, e.y[7:0], e.c, e.z);
            n_err++;
        end
        // Async reset mid-cycle clears immediately.
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (y8 !== 8'h00 || c8 !== 1'b0 || z8 !== 1'b1 || y32 !== 32'h0 || z32 !== 1'b1) begin
            $display("FAIL async_reset: got y8=%h c8=%b z8=%b y32=%h z32=%b, expected y8=00 c8=0 z8=1 y32=00000000 z32=1",
                     y8, c8, z8, y32, z32);
            n_err++;
        end
        #1;
        rst_n = 1'b1;
        push8(8'h6B, 8'h4A, 4'd1, 8'h21, 1'b0, 1'b0);
        @(posedge clk); #1;
        e = q8.pop_front();
        n_vec++;
        if (y8 !== e.y[7:0] || c8 !== e.c || z8 !== e.z) begin
            $display("FAIL post_reset: got y=%h c=%b z=%b, expected y=%h c=%b z=%b",
                     y8, c8, z8, e.y[7:0], e.c, e.z);
            n_err++;
        end
    endtask

    task automatic test_width32();
        logic [31:0] va [3], vb [3], vy [3];
        logic [3:0]  vf [3];
        logic        vc [3], vz [3];
        va = '{32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF};
        vb = '{32'h00000002, 32'h00000000, 32'h00000001};
        vf = '{4'd2, 4'd7, 4'd0};
        vy = '{32'hFFFFFFFE, 32'h00000000, 32'h00000000};
        vc = '{1'b1, 1'b1, 1'b1};
        vz = '{1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 3; i++) begin
            exp_t e;
            push32(va[i], vb[i], vf[i], vy[i], vc[i], vz[i]);
            @(posedge clk); #1;
            e = q32.pop_front();
            n_vec++;
            if (y32 !== e.y[31:0] || c32 !== e.c || z32 !== e.z) begin
                $display("FAIL w32[%0d]: got y=%h c=%b z=%b, expected y=%h c=%b z=%b",
                         i, y32, c32, z32, e.y[31:0], e.c, e.z);
                n_err++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_sweep();
        test_reserved();
        test_wrap();
        test_back_to_back();
        test_latency();
        test_width32();
        if (q8.size() != 0 || q32.size() != 0) begin
            $display("FAIL scoreboard_drain: got %0d/%0d entries left, expected 0/0", q8.size(), q32.size());
            n_err++;
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
